// File: rtl/slow_timer.sv
// Slow-speed request timer: holds Slow high while a slow peripheral is being
// accessed and for a programmable number of prescaler ticks afterwards.
module slow_timer #(
    parameter int PRE_W = 6
) (
    input  logic       CLK,
    input  logic       POR,
    input  logic       BACT,
    input  logic       IACKCS,
    input  logic       VIACS,
    input  logic       IWMCS,
    input  logic       SCCCS,
    input  logic       SCSICS,
    input  logic       SndCS,
    input  logic       SlowIACK,
    input  logic       SlowVIA,
    input  logic       SlowIWM,
    input  logic       SlowSCC,
    input  logic       SlowSCSI,
    input  logic       SlowSnd,
    input  logic       SlowClockGate,
    input  logic [3:0] SlowTimeout,
    output logic       Slow,
    output logic       ClockGate
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        HOLD
    } state_t;

    state_t           state, nextState;
    logic             BACTr;
    logic             bactArmed;
    logic [3:0]       cnt, nextCnt;
    logic [PRE_W-1:0] pre, nextPre;
    logic             accessStart;
    logic             qual;
    logic             tick;

    // bactArmed stays low after reset until BACT has been seen low, so a bus
    // cycle already running when POR drops is never mistaken for a new start.
    assign accessStart = BACT & ~BACTr & bactArmed;

    assign qual = (IACKCS & SlowIACK) | (VIACS & SlowVIA) | (IWMCS & SlowIWM) |
                  (SCCCS & SlowSCC) | (SCSICS & SlowSCSI) | (SndCS & SlowSnd);

    assign tick = &pre;

    assign ClockGate = Slow & SlowClockGate;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge CLK or posedge POR) begin
        if (POR) begin
            state     <= IDLE;
            Slow      <= 1'b0;
            cnt       <= 4'd0;
            pre       <= '0;
            BACTr     <= 1'b0;
            bactArmed <= 1'b0;
        end else begin
            state <= nextState;
            Slow  <= (nextState != IDLE);
            cnt   <= nextCnt;
            pre   <= nextPre;
            BACTr <= BACT;
            if (!BACT) begin
                bactArmed <= 1'b1;
            end
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a variable unassigned and infer a latch.
    always_comb begin
        nextState = state;
        nextCnt   = cnt;
        nextPre   = '0;
        case (state)
            IDLE: begin
                if (accessStart && qual) begin
                    nextState = ACCESS;
                end
            end
            ACCESS: begin
                if (!BACT) begin
                    if (SlowTimeout == 4'd0) begin
                        nextState = IDLE;
                    end else begin
                        nextState = HOLD;
                        nextCnt   = SlowTimeout;
                    end
                end
            end
            HOLD: begin
                nextPre = pre + 1'b1;
                // A qualified retrigger wins over a tick landing in the same cycle.
                if (accessStart && qual) begin
                    nextState = ACCESS;
                    nextPre   = '0;
                end else if (tick) begin
                    if (cnt == 4'd1) begin
                        nextState = IDLE;
                        nextCnt   = 4'd0;
                        nextPre   = '0;
                    end else begin
                        nextCnt = cnt - 1'b1;
                    end
                end
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_slow_timer.sv
// Scoreboard bench for slow_timer: a deadline-based reference model predicts
// Slow/ClockGate per clock edge; a monitor pops and compares after each edge.
module tb_slow_timer;

    localparam int PRE_W = 6;
    localparam int TICK  = 1 << PRE_W;

    typedef struct {
        logic slow;
        logic cg;
    } exp_t;

    logic       CLK;
    logic       POR;
    logic       BACT;
    logic [5:0] cs;
    logic [5:0] en;
    logic       SlowClockGate;
    logic [3:0] SlowTimeout;
    logic       Slow;
    logic       ClockGate;

    int checks = 0;
    int errors = 0;

    exp_t expQ[$];

    // Reference model: an episode is "in access" or "holding until edge N".
    logic    mAccess   = 1'b0;
    logic    mHold     = 1'b0;
    logic    mPrevBact = 1'b0;
    logic    mArmed    = 1'b0;
    longint  mEdge     = 0;
    longint  mHoldUntil = 0;

    slow_timer #(.PRE_W(PRE_W)) dut (
        .CLK          (CLK),
        .POR          (POR),
        .BACT         (BACT),
        .IACKCS       (cs[5]),
        .VIACS        (cs[4]),
        .IWMCS        (cs[3]),
        .SCCCS        (cs[2]),
        .SCSICS       (cs[1]),
        .SndCS        (cs[0]),
        .SlowIACK     (en[5]),
        .SlowVIA      (en[4]),
        .SlowIWM      (en[3]),
        .SlowSCC      (en[2]),
        .SlowSCSI     (en[1]),
        .SlowSnd      (en[0]),
        .SlowClockGate(SlowClockGate),
        .SlowTimeout  (SlowTimeout),
        .Slow         (Slow),
        .ClockGate    (ClockGate)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Called right after a falling edge with inputs already set: predicts the
    // outputs after the coming rising edge, queues them, waits for next fall.
    task automatic step();
        exp_t e;
        logic start;
        logic qual;
        if (POR) begin
            mAccess   = 1'b0;
            mHold     = 1'b0;
            mPrevBact = 1'b0;
            mArmed    = 1'b0;
        end else begin
            start = BACT && !mPrevBact && mArmed;
            qual  = |(cs & en);
            if (mAccess) begin
                if (!BACT) begin
                    mAccess = 1'b0;
                    if (SlowTimeout != 4'd0) begin
                        mHold      = 1'b1;
                        mHoldUntil = mEdge + longint'(SlowTimeout) * TICK;
                    end
                end
            end else if (start && qual) begin
                mAccess = 1'b1;
                mHold   = 1'b0;
            end else if (mHold && mEdge >= mHoldUntil) begin
                mHold = 1'b0;
            end
            mPrevBact = BACT;
            if (!BACT) mArmed = 1'b1;
        end
        e.slow = mAccess || mHold;
        e.cg   = e.slow && SlowClockGate;
        expQ.push_back(e);
        mEdge++;
        @(negedge CLK);
    endtask

    always @(posedge CLK) begin
        exp_t e;
        #1;
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            check("sb_slow", 32'(Slow), 32'(e.slow));
            check("sb_clockgate", 32'(ClockGate), 32'(e.cg));
        end
    end

    initial begin
        int phaseLeft;
        POR           = 1'b1;
        BACT          = 1'b0;
        cs            = 6'b0;
        en            = 6'b0;
        SlowClockGate = 1'b1;
        SlowTimeout   = 4'd0;
        @(negedge CLK);
        check("reset_slow", 32'(Slow), 32'd0);
        check("reset_clockgate", 32'(ClockGate), 32'd0);
        step();
        POR           = 1'b0;
        SlowClockGate = 1'b0;

        // VIA access with a 3-tick hold
        cs = 6'b010000; en = 6'b010000; SlowTimeout = 4'd3;
        step();
        check("via_idle", 32'(Slow), 32'd0);
        BACT = 1'b1;
        step();
        check("via_rise", 32'(Slow), 32'd1);
        repeat (3) step();
        BACT = 1'b0;
        step();
        repeat (191) step();
        check("via_hold_last", 32'(Slow), 32'd1);
        step();
        check("via_hold_end", 32'(Slow), 32'd0);

        // SCSI selected but not enabled for slow
        cs = 6'b000010; en = 6'b111101;
        for (int i = 0; i < 8; i++) begin
            BACT = (i >= 1 && i <= 3);
            step();
            check("scsi_unqual", 32'(Slow), 32'd0);
        end

        // IWM with zero timeout
        cs = 6'b001000; en = 6'b001000; SlowTimeout = 4'd0;
        BACT = 1'b1;
        step();
        step();
        check("iwm_access", 32'(Slow), 32'd1);
        BACT = 1'b0;
        step();
        check("iwm_release", 32'(Slow), 32'd0);

        // SCC retrigger landing exactly on the final tick
        cs = 6'b000100; en = 6'b000100; SlowTimeout = 4'd1;
        step();
        BACT = 1'b1;
        step();
        BACT = 1'b0;
        step();
        repeat (63) step();
        check("scc_hold_before_tick", 32'(Slow), 32'd1);
        SlowTimeout = 4'd2;
        BACT = 1'b1;
        step();
        check("scc_retrigger", 32'(Slow), 32'd1);
        BACT = 1'b0;
        step();
        repeat (127) step();
        check("scc_reload_last", 32'(Slow), 32'd1);
        step();
        check("scc_reload_end", 32'(Slow), 32'd0);

        // POR while holding, released with BACT still high
        cs = 6'b010000; en = 6'b010000; SlowTimeout = 4'd3;
        BACT = 1'b1;
        step();
        BACT = 1'b0;
        step();
        repeat (10) step();
        cs = 6'b0;
        BACT = 1'b1;
        step();
        check("hold_ignores_unqual", 32'(Slow), 32'd1);
        SlowClockGate = 1'b1;
        POR = 1'b1;
        #1;
        check("por_async_slow", 32'(Slow), 32'd0);
        check("por_async_clockgate", 32'(ClockGate), 32'd0);
        step();
        POR = 1'b0;
        cs = 6'b010000;
        for (int i = 0; i < 4; i++) begin
            step();
            check("por_no_start", 32'(Slow), 32'd0);
        end
        BACT = 1'b0;
        step();
        BACT = 1'b1;
        step();
        check("por_next_edge", 32'(Slow), 32'd1);

        // ClockGate follows SlowClockGate combinationally
        SlowClockGate = 1'b0;
        #1;
        check("cg_follow_low", 32'(ClockGate), 32'd0);
        SlowClockGate = 1'b1;
        #1;
        check("cg_follow_high", 32'(ClockGate), 32'd1);
        step();
        BACT = 1'b0; SlowTimeout = 4'd0;
        step();
        check("cg_idle_slow", 32'(Slow), 32'd0);
        check("cg_idle", 32'(ClockGate), 32'd0);

        // Randomised bus traffic, settings churn and occasional resets
        phaseLeft = 0;
        for (int i = 0; i < 5000; i++) begin
            if (phaseLeft == 0) begin
                BACT = !BACT;
                if (BACT) phaseLeft = $urandom_range(1, 5);
                else if ($urandom_range(0, 2) == 0) phaseLeft = $urandom_range(40, 220);
                else phaseLeft = $urandom_range(1, 20);
            end
            phaseLeft--;
            cs            = 6'(1 << $urandom_range(0, 6));
            en            = 6'($urandom);
            SlowTimeout   = 4'($urandom_range(0, 3));
            SlowClockGate = 1'($urandom);
            POR           = ($urandom_range(0, 499) == 0);
            step();
        end
        POR = 1'b0;

        @(posedge CLK);
        #2;
        check("scoreboard_drained", 32'(expQ.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
